// File: rtl/tetris_input_arbiter.sv
// tetris_input_arbiter
//   Front end between the four player buttons and the game core. Raw pad
//   inputs are synchronized and debounced. Presses and held buttons become
//   move events with auto-repeat. At most one move command per video frame
//   goes to the core, with the buttons sharing that slot round-robin.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high; clears all state
//   butt_in     raw buttons: 0 = left, 1 = right, 2 = rotate, 3 = drop
//   frame_tick  one-cycle pulse per video frame
//   pressed     debounced button levels
//   cmd_valid   command offered to the game core
//   cmd_ready   game core accepts the command
//   cmd         button index of the offered command
//   cmd_repeat  1 = auto-repeat command, 0 = fresh press
//   dbg_state   arbiter FSM state (0 = IDLE, 1 = OFFER)
//
// Handshake: cmd_valid, cmd and cmd_repeat are held stable until the cycle
// where cmd_valid & cmd_ready are both high. The transfer completes at the
// rising edge that ends that cycle. cmd_valid does not depend on cmd_ready.
module tetris_input_arbiter #(
    parameter int DEBOUNCE_CYCLES     = 50000,
    parameter int REPEAT_DELAY_FRAMES = 15,
    parameter int REPEAT_RATE_FRAMES  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] butt_in,
    input  logic       frame_tick,
    output logic [3:0] pressed,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd,
    output logic       cmd_repeat,
    output logic       dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam logic [15:0] DB_LAST    = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [5:0]  RPT_DELAY  = 6'(REPEAT_DELAY_FRAMES);
    localparam logic [5:0]  RPT_RELOAD = 6'(REPEAT_DELAY_FRAMES - REPEAT_RATE_FRAMES);
    // Rotate (bit 2) never auto-repeats.
    localparam logic [3:0]  RPT_MASK   = 4'b1011;

    logic [3:0]  sync1_q, sync1_d;
    logic [3:0]  sync2_q, sync2_d;
    logic [3:0]  pressed_q, pressed_d;
    logic [3:0]  pressed_prev_q, pressed_prev_d;
    logic [15:0] db_cnt_q [4];
    logic [15:0] db_cnt_d [4];
    logic [5:0]  rpt_cnt_q [4];
    logic [5:0]  rpt_cnt_d [4];
    logic [3:0]  pend_q, pend_d;
    logic [3:0]  rep_q, rep_d;
    state_t      state_q, state_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [1:0]  last_q, last_d;
    logic        cmd_repeat_q, cmd_repeat_d;

    logic [3:0]  press_edge;
    logic [5:0]  rpt_inc;
    logic        handshake;
    logic        grant_found;
    logic [1:0]  grant_idx;
    logic [1:0]  cand;

    assign handshake = (state_q == OFFER) && cmd_ready;

    // Synchronizer and debounce. A level change is accepted only after
    // DEBOUNCE_CYCLES consecutive mismatching samples.
    always_comb begin
        sync1_d        = butt_in;
        sync2_d        = sync1_q;
        pressed_d      = pressed_q;
        pressed_prev_d = pressed_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = 16'd0;
            if (sync2_q[i] != pressed_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    pressed_d[i] = ~pressed_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    // Press / repeat events and the sticky pending bits. New events are
    // applied after the handshake clear, so an event in the same cycle wins.
    always_comb begin
        press_edge = pressed_q & ~pressed_prev_q;
        pend_d     = pend_q;
        rep_d      = rep_q;
        rpt_inc    = 6'd0;
        if (handshake) begin
            pend_d[cmd_q] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            rpt_cnt_d[i] = rpt_cnt_q[i];
            if (press_edge[i]) begin
                pend_d[i] = 1'b1;
                rep_d[i]  = 1'b0;
            end
            if (!RPT_MASK[i] || !pressed_q[i] || press_edge[i]) begin
                rpt_cnt_d[i] = 6'd0;
            end else if (frame_tick) begin
                rpt_inc = rpt_cnt_q[i] + 6'd1;
                if (rpt_inc == RPT_DELAY) begin
                    pend_d[i]    = 1'b1;
                    rep_d[i]     = 1'b1;
                    // Reloading DELAY-RATE makes later repeats RATE ticks apart.
                    rpt_cnt_d[i] = RPT_RELOAD;
                end else begin
                    rpt_cnt_d[i] = rpt_inc;
                end
            end
        end
    end

    // Arbiter FSM: round-robin search starts at the button after the last grant.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        cmd_repeat_d = cmd_repeat_q;
        last_d       = last_q;
        grant_found  = 1'b0;
        grant_idx    = 2'd0;
        cand         = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!grant_found && pend_q[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        case (state_q)
            IDLE: begin
                if (frame_tick && grant_found) begin
                    state_d      = OFFER;
                    cmd_d        = grant_idx;
                    cmd_repeat_d = rep_q[grant_idx];
                    last_d       = grant_idx;
                end
            end
            OFFER: begin
                if (cmd_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q        <= 4'd0;
            sync2_q        <= 4'd0;
            pressed_q      <= 4'd0;
            pressed_prev_q <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i]  <= 16'd0;
                rpt_cnt_q[i] <= 6'd0;
            end
            pend_q         <= 4'd0;
            rep_q          <= 4'd0;
            state_q        <= IDLE;
            cmd_q          <= 2'd0;
            cmd_repeat_q   <= 1'b0;
            last_q         <= 2'd3;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            pressed_q      <= pressed_d;
            pressed_prev_q <= pressed_prev_d;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i]  <= db_cnt_d[i];
                rpt_cnt_q[i] <= rpt_cnt_d[i];
            end
            pend_q         <= pend_d;
            rep_q          <= rep_d;
            state_q        <= state_d;
            cmd_q          <= cmd_d;
            cmd_repeat_q   <= cmd_repeat_d;
            last_q         <= last_d;
        end
    end

    assign pressed    = pressed_q;
    assign cmd_valid  = (state_q == OFFER);
    assign cmd        = cmd_q;
    assign cmd_repeat = cmd_repeat_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_tetris_input_arbiter.sv
// Bench for tetris_input_arbiter with DEBOUNCE_CYCLES=4, REPEAT_DELAY_FRAMES=3,
// REPEAT_RATE_FRAMES=2. Inputs are driven 1 time unit after the rising edge.
// The expected command stream is queued as {cmd_repeat, cmd} when the
// stimulus is driven. Commands are popped at every accepted handshake,
// sampled on the falling edge.
module tb_tetris_input_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] butt_in;
    logic       frame_tick;
    logic [3:0] pressed;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic       cmd_repeat;
    logic       dbg_state;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [2:0] exp_q[$];
    logic [2:0] mon_exp;
    // Ticks 1..9 of a held left button that should produce an offer.
    logic [8:0] rpt_pat = 9'b010101001;

    always #5 clk = ~clk;

    tetris_input_arbiter #(
        .DEBOUNCE_CYCLES    (4),
        .REPEAT_DELAY_FRAMES(3),
        .REPEAT_RATE_FRAMES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .butt_in   (butt_in),
        .frame_tick(frame_tick),
        .pressed   (pressed),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .cmd_repeat(cmd_repeat),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        cycles(1);
        frame_tick = 1'b0;
    endtask

    // Hold the given buttons long enough to debounce, then release fully.
    task automatic tap(input logic [3:0] b);
        butt_in = b;
        cycles(8);
        butt_in = 4'b0000;
        cycles(8);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(1);
    endtask

    // Scoreboard side: every accepted command must match the queue head.
    always @(negedge clk) begin
        if (!reset && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_cmd", 32'(cmd_valid), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("cmd", 32'({cmd_repeat, cmd}), 32'(mon_exp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        butt_in    = 4'b0000;
        frame_tick = 1'b0;
        cmd_ready  = 1'b1;
        cycles(2);
        check("rst_pressed", 32'(pressed), 32'd0);
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_repeat", 32'(cmd_repeat), 32'd0);
        reset = 1'b0;
        cycles(2);

        // Glitch filter: 3-cycle pulse is rejected, a held level is accepted.
        butt_in = 4'b0001;
        cycles(3);
        butt_in = 4'b0000;
        cycles(10);
        check("glitch_pressed", 32'(pressed), 32'd0);
        frame();
        check("glitch_nocmd", 32'(cmd_valid), 32'd0);
        cycles(3);
        butt_in = 4'b0001;
        cycles(5);
        check("db_before_edge", 32'(pressed[0]), 32'd0);
        cycles(1);
        check("db_at_edge", 32'(pressed[0]), 32'd1);
        cycles(4);
        butt_in = 4'b0000;
        cycles(8);
        check("db_release", 32'(pressed), 32'd0);
        exp_q.push_back({1'b0, 2'd0});
        frame();
        check("held_grant", 32'(cmd_valid), 32'd1);
        cycles(1);
        check("one_cycle_offer", 32'(cmd_valid), 32'd0);
        cycles(2);

        // Tap delivery: rotate pressed and released between frames.
        tap(4'b0100);
        exp_q.push_back({1'b0, 2'd2});
        frame();
        check("tap_grant", 32'(cmd_valid), 32'd1);
        cycles(1);
        check("tap_offer_len", 32'(cmd_valid), 32'd0);
        cycles(2);
        frame();
        check("tap_once", 32'(cmd_valid), 32'd0);
        cycles(3);

        // Round-robin from reset priority.
        do_reset();
        tap(4'b1011);
        exp_q.push_back({1'b0, 2'd0});
        exp_q.push_back({1'b0, 2'd1});
        exp_q.push_back({1'b0, 2'd3});
        for (int k = 0; k < 3; k++) begin
            frame();
            check("rr_grant", 32'(cmd_valid), 32'd1);
            cycles(3);
        end
        frame();
        check("rr_done", 32'(cmd_valid), 32'd0);
        cycles(3);

        // Auto-repeat on a held left button: pends on ticks 3, 5, 7, 9.
        butt_in = 4'b0001;
        cycles(8);
        exp_q.push_back({1'b0, 2'd0});
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, 2'd0});
        for (int k = 0; k < 9; k++) begin
            frame();
            check("rpt_tick", 32'(cmd_valid), 32'(rpt_pat[k]));
            cycles(3);
        end
        butt_in = 4'b0000;
        cycles(8);
        frame();
        check("rpt_last", 32'(cmd_valid), 32'd1);
        cycles(3);

        // Held rotate gives exactly one command.
        butt_in = 4'b0100;
        cycles(8);
        exp_q.push_back({1'b0, 2'd2});
        for (int k = 0; k < 9; k++) begin
            frame();
            check("rot_tick", 32'(cmd_valid), 32'(k == 0));
            cycles(3);
        end
        butt_in = 4'b0000;
        cycles(8);
        frame();
        check("rot_no_more", 32'(cmd_valid), 32'd0);
        cycles(3);

        // Backpressure: right stays offered, ticks during OFFER are ignored.
        tap(4'b0010);
        exp_q.push_back({1'b0, 2'd1});
        exp_q.push_back({1'b0, 2'd0});
        cmd_ready = 1'b0;
        frame();
        for (int i = 0; i < 20; i++) begin
            if (i == 0) butt_in = 4'b0001;
            if (i == 8) butt_in = 4'b0000;
            frame_tick = (i == 12) || (i == 17);
            check("bp_valid", 32'(cmd_valid), 32'd1);
            check("bp_cmd", 32'(cmd), 32'd1);
            cycles(1);
        end
        frame_tick = 1'b0;
        cmd_ready  = 1'b1;
        cycles(1);
        check("bp_release", 32'(cmd_valid), 32'd0);
        cycles(2);
        frame();
        check("bp_next_grant", 32'(cmd_valid), 32'd1);
        cycles(3);

        // Reset during an offer drops it; priority restarts at button 0.
        butt_in = 4'b1111;
        cycles(8);
        cmd_ready = 1'b0;
        frame();
        check("mid_offer_valid", 32'(cmd_valid), 32'd1);
        check("mid_offer_cmd", 32'(cmd), 32'd1);
        check("mid_offer_pressed", 32'(pressed), 32'hf);
        butt_in = 4'b0000;
        reset   = 1'b1;
        #1;
        check("async_pressed", 32'(pressed), 32'd0);
        check("async_valid", 32'(cmd_valid), 32'd0);
        check("async_cmd", 32'(cmd), 32'd0);
        check("async_repeat", 32'(cmd_repeat), 32'd0);
        cycles(2);
        reset     = 1'b0;
        cmd_ready = 1'b1;
        cycles(8);
        frame();
        check("post_rst_idle", 32'(cmd_valid), 32'd0);
        cycles(3);
        tap(4'b1111);
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, 2'(k)});
        for (int k = 0; k < 4; k++) begin
            frame();
            check("post_rst_grant", 32'(cmd_valid), 32'd1);
            cycles(3);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
